// File: rtl/spi_master_mc_if.sv
// Control-side bus of spi_master_mc: transfer request, per-transfer settings and RX result.
interface spi_master_mc_if #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_CS       = 4,
  parameter int unsigned DIV_WIDTH    = 8,
  parameter int unsigned CS_SEL_WIDTH = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  parameter int unsigned LEN_WIDTH    = $clog2(DATA_WIDTH + 1)
);
  logic                    start;
  logic                    cpol;
  logic                    cpha;
  logic [DIV_WIDTH-1:0]    clk_div;
  logic [LEN_WIDTH-1:0]    word_len;
  logic [CS_SEL_WIDTH-1:0] cs_sel;
  logic [DATA_WIDTH-1:0]   data_in;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    busy;
  logic                    new_data;

  modport master (
    output start, cpol, cpha, clk_div, word_len, cs_sel, data_in,
    input  data_out, busy, new_data
  );

  modport slave (
    input  start, cpol, cpha, clk_div, word_len, cs_sel, data_in,
    output data_out, busy, new_data
  );
endinterface

// File: rtl/spi_master_mc.sv
// Multi-mode SPI master: runtime CPOL/CPHA, clock divider, word length and one-hot chip select.
module spi_master_mc #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_CS       = 4,
  parameter int unsigned DIV_WIDTH    = 8,
  parameter int unsigned CS_SEL_WIDTH = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  parameter int unsigned LEN_WIDTH    = $clog2(DATA_WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  spi_master_mc_if.slave     bus,
  input  logic               miso,
  output logic               mosi,
  output logic               sck,
  output logic [NUM_CS-1:0]  cs_n
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    TRANSFER = 2'd2,
    CS_HOLD  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic [DIV_WIDTH-1:0]  h_q, h_d;
  logic [LEN_WIDTH-1:0]  n_q, n_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [LEN_WIDTH-1:0]  bit_q, bit_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;
  logic [NUM_CS-1:0]     cs_n_q, cs_n_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  nd_q, nd_d;

  logic                  accept;
  logic [LEN_WIDTH-1:0]  n_eff;
  logic [DATA_WIDTH-1:0] tx_al;
  logic                  leading;
  logic                  last_edge;

  assign accept = bus.start && ({1'b0, bus.cs_sel} < (CS_SEL_WIDTH + 1)'(NUM_CS));
  assign n_eff  = (bus.word_len == '0 || bus.word_len > LEN_WIDTH'(DATA_WIDTH))
                  ? LEN_WIDTH'(DATA_WIDTH) : bus.word_len;
  // TX word is left-aligned so the current bit is always the MSB of the shifter.
  assign tx_al  = bus.data_in << (LEN_WIDTH'(DATA_WIDTH) - n_eff);

  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    h_d       = h_q;
    n_d       = n_q;
    div_d     = div_q;
    bit_d     = bit_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    dout_d    = dout_q;
    nd_d      = 1'b0;
    leading   = 1'b0;
    last_edge = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CS_SETUP;
          cpol_d  = bus.cpol;
          cpha_d  = bus.cpha;
          h_d     = bus.clk_div;
          n_d     = n_eff;
          div_d   = '0;
          bit_d   = '0;
          sck_d   = bus.cpol;
          cs_n_d  = ~(NUM_CS'(1) << bus.cs_sel);
          rx_d    = '0;
          if (!bus.cpha) begin
            mosi_d = tx_al[DATA_WIDTH-1];
            tx_d   = tx_al << 1;
          end else begin
            tx_d   = tx_al;
          end
        end
      end

      CS_SETUP: begin
        if (div_q == h_q) begin
          state_d = TRANSFER;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      TRANSFER: begin
        if (div_q != h_q) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d   = '0;
          sck_d   = ~sck_q;
          // A leading edge always moves sck away from its idle level.
          leading = (sck_q == cpol_q);
          if (leading) begin
            if (!cpha_q) begin
              rx_d  = {rx_q[DATA_WIDTH-2:0], miso};
              bit_d = bit_q + 1'b1;
            end else begin
              mosi_d = tx_q[DATA_WIDTH-1];
              tx_d   = tx_q << 1;
            end
          end else begin
            last_edge = cpha_q ? (bit_q == n_q - 1'b1) : (bit_q == n_q);
            if (cpha_q) begin
              rx_d  = {rx_q[DATA_WIDTH-2:0], miso};
              bit_d = bit_q + 1'b1;
            end else if (!last_edge) begin
              mosi_d = tx_q[DATA_WIDTH-1];
              tx_d   = tx_q << 1;
            end
            if (last_edge) begin
              state_d = CS_HOLD;
            end
          end
        end
      end

      CS_HOLD: begin
        if (div_q == h_q) begin
          state_d = IDLE;
          div_d   = '0;
          cs_n_d  = '1;
          dout_d  = rx_q;
          nd_d    = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      h_q     <= '0;
      n_q     <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= '1;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      nd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      h_q     <= h_d;
      n_q     <= n_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      nd_q    <= nd_d;
    end
  end

  assign sck          = sck_q;
  assign mosi         = mosi_q;
  assign cs_n         = cs_n_q;
  assign bus.data_out = dout_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.new_data = nd_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc with a mode-aware SPI slave model and edge/cycle monitors.
module tb_spi_master_mc;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       miso;
  logic       mosi;
  logic       sck;
  logic [3:0] cs_n;

  spi_master_mc_if #(
    .DATA_WIDTH(16), .NUM_CS(4), .DIV_WIDTH(8), .CS_SEL_WIDTH(3), .LEN_WIDTH(5)
  ) bus ();

  spi_master_mc #(
    .DATA_WIDTH(16), .NUM_CS(4), .DIV_WIDTH(8), .CS_SEL_WIDTH(3), .LEN_WIDTH(5)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .miso (miso),
    .mosi (mosi),
    .sck  (sck),
    .cs_n (cs_n)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave model and monitors, all sampled on the falling clk edge.
  logic        loop = 1'b0;
  logic        slv_cpol = 1'b0, slv_cpha = 1'b0;
  int unsigned slv_n = 16;
  logic [15:0] slv_word = '0, slv_sh = '0, slv_rx = '0;
  logic        slv_miso = 1'b0;
  logic        cs_act, sck_p = 1'b0, cs_p = 1'b0, lead;
  int unsigned cyc = 0, rises = 0, busy_cyc = 0, nd_cnt = 0;
  int unsigned hi_run = 0, last_gap = 0, prev_rise = 0, last_period = 0;

  assign cs_act = ~&cs_n;
  assign miso   = loop ? mosi : slv_miso;

  always @(negedge clk) begin
    cyc++;
    if (bus.busy) busy_cyc++;
    if (bus.new_data) nd_cnt++;
    if (cs_act && !cs_p) begin
      last_gap = hi_run;
      slv_sh   = slv_word << (16 - slv_n);
      slv_rx   = '0;
      if (!slv_cpha) begin
        slv_miso = slv_sh[15];
        slv_sh   = slv_sh << 1;
      end
    end else if (cs_act && sck != sck_p) begin
      if (sck && !sck_p) begin
        rises++;
        last_period = cyc - prev_rise;
        prev_rise   = cyc;
      end
      lead = (sck != slv_cpol);
      if (lead ^ slv_cpha) begin
        slv_rx = {slv_rx[14:0], mosi};
      end else begin
        slv_miso = slv_sh[15];
        slv_sh   = slv_sh << 1;
      end
    end
    hi_run = cs_act ? 0 : hi_run + 1;
    sck_p  = sck;
    cs_p   = cs_act;
  end

  logic        last_cpol = 1'b0;
  logic        exp_cpol;
  logic [3:0]  exp_cs;
  logic [15:0] exp_din, exp_sw;
  int unsigned exp_n, exp_h, b0, r0, n0;

  task automatic start_xfer(input logic cp, input logic ph, input logic [7:0] div,
                            input logic [4:0] len, input logic [2:0] sel,
                            input logic [15:0] din, input logic [15:0] sw,
                            input logic lb, input logic hold);
    @(negedge clk);
    b0 = busy_cyc; r0 = rises; n0 = nd_cnt;
    check("sck_idle", sck, last_cpol);
    exp_n    = (len == 0 || len > 16) ? 16 : len;
    exp_h    = div + 1;
    exp_cs   = ~(4'b0001 << sel);
    exp_din  = din;
    exp_sw   = sw;
    exp_cpol = cp;
    bus.cpol = cp; bus.cpha = ph; bus.clk_div = div; bus.word_len = len;
    bus.cs_sel = sel; bus.data_in = din;
    slv_cpol = cp; slv_cpha = ph; slv_n = exp_n; slv_word = sw; loop = lb;
    bus.start = 1'b1;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    check("cs_setup", cs_n, exp_cs);
    check("sck_setup", sck, cp);
    check("busy_on", bus.busy, 1'b1);
  endtask

  task automatic wait_nd(output logic got);
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (bus.new_data) got = 1'b1;
    end
    check("nd_timeout", got, 1'b1);
  endtask

  task automatic finish_xfer(input int unsigned words);
    logic        got;
    int unsigned mask;
    mask = (32'd1 << exp_n) - 1;
    wait_nd(got);
    check("data_out", bus.data_out, exp_sw & mask);
    check("mosi_bits", slv_rx, exp_din & mask);
    check("busy_in_nd", bus.busy, 1'b0);
    repeat (2) @(negedge clk);
    check("busy_cycles", busy_cyc - b0, words * (2 * exp_n + 2) * exp_h);
    check("sck_rises", rises - r0, words * exp_n);
    check("nd_pulses", nd_cnt - n0, words);
    check("cs_idle", cs_n, 4'hF);
    check("sck_after", sck, exp_cpol);
    last_cpol = exp_cpol;
  endtask

  initial begin
    logic got;
    bus.start = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.clk_div = '0;
    bus.word_len = '0; bus.cs_sel = '0; bus.data_in = '0;

    @(negedge clk);
    check("rst_sck", sck, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_cs_n", cs_n, 4'hF);
    check("rst_dout", bus.data_out, 16'h0000);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_nd", bus.new_data, 1'b0);
    rst = 1'b1;

    // Mode 0 loopback, full word, fastest clock.
    start_xfer(1'b0, 1'b0, 8'd0, 5'd16, 3'd0, 16'hA5C3, 16'hA5C3, 1'b1, 1'b0);
    finish_xfer(1);

    // Mode 3, 8-bit word, H=4, device 2.
    start_xfer(1'b1, 1'b1, 8'd3, 5'd8, 3'd2, 16'h00F0, 16'h003C, 1'b0, 1'b0);
    finish_xfer(1);
    check("m3_period", last_period, 8);

    // Modes 1 and 2, 12-bit words.
    start_xfer(1'b0, 1'b1, 8'd1, 5'd12, 3'd1, 16'h05A3, 16'h0ABC, 1'b0, 1'b0);
    finish_xfer(1);
    start_xfer(1'b1, 1'b0, 8'd2, 5'd12, 3'd3, 16'h0C35, 16'h0ABC, 1'b0, 1'b0);
    finish_xfer(1);

    // Start while busy is ignored.
    start_xfer(1'b0, 1'b0, 8'd1, 5'd16, 3'd0, 16'h0F0F, 16'h6006, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    bus.data_in = 16'h1234; bus.cs_sel = 3'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("mid_cs_n", cs_n, 4'hE);
    finish_xfer(1);

    // Out-of-range device index is ignored.
    n0 = nd_cnt;
    bus.cs_sel = 3'd5; bus.start = 1'b1;
    repeat (4) @(negedge clk);
    check("bad_sel_busy", bus.busy, 1'b0);
    check("bad_sel_cs_n", cs_n, 4'hF);
    bus.start = 1'b0;
    @(negedge clk);
    check("bad_sel_nd", nd_cnt - n0, 0);
    check("bad_sel_dout", bus.data_out, 16'h6006);

    // Back-to-back with start held high; word_len=0 means 16 bits.
    start_xfer(1'b0, 1'b0, 8'd0, 5'd0, 3'd3, 16'h1357, 16'hBEEF, 1'b0, 1'b1);
    bus.data_in = 16'h2468;
    @(negedge clk);
    slv_word = 16'h7E81;
    wait_nd(got);
    check("b2b_dout1", bus.data_out, 16'hBEEF);
    check("b2b_mosi1", slv_rx, 16'h1357);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_cs2", cs_n, 4'h7);
    exp_din = 16'h2468;
    exp_sw  = 16'h7E81;
    finish_xfer(2);
    check("b2b_gap", last_gap, 1);

    // Asynchronous reset in the middle of a word.
    start_xfer(1'b0, 1'b0, 8'd0, 5'd16, 3'd1, 16'hC0DE, 16'h1DEA, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    n0 = nd_cnt;
    rst = 1'b0;
    #1;
    check("arst_cs_n", cs_n, 4'hF);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_sck", sck, 1'b0);
    check("arst_dout", bus.data_out, 16'h0000);
    check("arst_mosi", mosi, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_nd", nd_cnt - n0, 0);
    last_cpol = 1'b0;
    start_xfer(1'b0, 1'b0, 8'd0, 5'd16, 3'd1, 16'hC0DE, 16'h1DEA, 1'b0, 1'b0);
    finish_xfer(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
